// File: rtl/fuzz_stim_packer_if.sv
// fuzz_stim_packer_if
// Bundles the byte-stream input handshake and the stimulus-frame output of
// fuzz_stim_packer.
//   byte_i / byte_valid_i / byte_ready_o : raw fuzz byte stream in
//   stim_valid_o / stim_ready_i          : frame handshake out
//   stall_o, code_o, code_ready_o, data_o, data_ready_o, data_addr_ext_o,
//   ext_irq_o, tmr_irq_o, sft_irq_o      : frame fields
//   init_pc_o                            : constant reset PC
//   frame_cnt_o                          : frames delivered since reset
// Modport slave is the packer side; master is the producer/consumer side.
interface fuzz_stim_packer_if #(
  parameter int XLEN = 32
);
  logic [7:0]      byte_i;
  logic            byte_valid_i;
  logic            byte_ready_o;
  logic            stim_valid_o;
  logic            stim_ready_i;
  logic            stall_o;
  logic [XLEN-1:0] code_o;
  logic            code_ready_o;
  logic [XLEN-1:0] data_o;
  logic            data_ready_o;
  logic            data_addr_ext_o;
  logic            ext_irq_o;
  logic            tmr_irq_o;
  logic            sft_irq_o;
  logic [XLEN-1:0] init_pc_o;
  logic [15:0]     frame_cnt_o;

  modport slave (
    input  byte_i, byte_valid_i, stim_ready_i,
    output byte_ready_o, stim_valid_o, stall_o, code_o, code_ready_o,
           data_o, data_ready_o, data_addr_ext_o, ext_irq_o, tmr_irq_o,
           sft_irq_o, init_pc_o, frame_cnt_o
  );

  modport master (
    output byte_i, byte_valid_i, stim_ready_i,
    input  byte_ready_o, stim_valid_o, stall_o, code_o, code_ready_o,
           data_o, data_ready_o, data_addr_ext_o, ext_irq_o, tmr_irq_o,
           sft_irq_o, init_pc_o, frame_cnt_o
  );
endinterface

// File: rtl/fuzz_stim_packer.sv
// fuzz_stim_packer
// Parses a raw fuzz byte stream into per-cycle stimulus frames for the
// fuzz-harness core wrapper and buffers them in a small FIFO.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : fuzz_stim_packer_if.slave (byte input, frame output, init_pc,
//            frame counter)
// Byte stream: control byte {has_words, sft, tmr, ext, addr_ext, data_ready,
// code_ready, stall}, optionally followed by XLEN/8 code bytes and XLEN/8
// data bytes, little-endian.
// Optional feature macro STIM_IDLE_FILL_EN: when the FIFO is empty an idle
// frame (stall=1, held words, other bits 0) is presented as valid; popping it
// does not advance frame_cnt_o.
//
// state  | meaning
// S_CTRL | waiting for / consuming the control byte
// S_CODE | consuming code word bytes
// S_DATA | consuming data word bytes
// S_PUSH | writing the assembled frame into the FIFO (no byte consumed)
module fuzz_stim_packer #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] INIT_PC    = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  fuzz_stim_packer_if.slave  bus
);

  localparam int              NB     = XLEN / 8;
  localparam int              KW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int              AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              FW     = 7 + 2 * XLEN;
  localparam logic [KW-1:0]   K_LAST = KW'(NB - 1);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_CTRL, S_CODE, S_DATA, S_PUSH} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [7:0]      ctrl_q;
  logic [XLEN-1:0] code_asm_q, data_asm_q;
  logic [XLEN-1:0] code_q, data_q;
  logic [FW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [15:0]     frame_cnt_q;

  logic            empty, full, byte_fire, pop, push;
  logic [FW-1:0]   push_frame, out_frame;
  logic            out_valid;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Ready is gated by reset so the producer sees 0 while held in reset.
  assign bus.byte_ready_o = rst_ni && (state_q != S_PUSH) && !full;
  assign byte_fire        = bus.byte_valid_i && bus.byte_ready_o;
  assign pop              = !empty && bus.stim_ready_i;
  // Full is judged after this cycle's pop, so a pop frees room for the push.
  assign push             = (state_q == S_PUSH) && (!full || pop);

  // Frames without words reuse the held words from the last worded frame.
  assign push_frame = {ctrl_q[6:0],
                       ctrl_q[7] ? code_asm_q : code_q,
                       ctrl_q[7] ? data_asm_q : data_q};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      S_CTRL: begin
        if (byte_fire) begin
          k_d     = '0;
          state_d = bus.byte_i[7] ? S_CODE : S_PUSH;
        end
      end
      S_CODE: begin
        if (byte_fire) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_DATA;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_DATA: begin
        if (byte_fire) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_PUSH;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_PUSH: begin
        if (push) state_d = S_CTRL;
      end
      default: state_d = S_CTRL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_CTRL;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q      <= '0;
      code_asm_q  <= '0;
      data_asm_q  <= '0;
      code_q      <= '0;
      data_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (byte_fire) begin
        if (state_q == S_CTRL) ctrl_q <= bus.byte_i;
        for (int i = 0; i < NB; i++) begin
          if (k_q == KW'(i)) begin
            if (state_q == S_CODE) code_asm_q[i*8 +: 8] <= bus.byte_i;
            if (state_q == S_DATA) data_asm_q[i*8 +: 8] <= bus.byte_i;
          end
        end
      end
      // Held words only change once a worded frame is actually committed.
      if (push && ctrl_q[7]) begin
        code_q <= code_asm_q;
        data_q <= data_asm_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_frame;
  end

  always_comb begin
    out_valid = 1'b0;
    out_frame = '0;
    if (rst_ni && !empty) begin
      out_valid = 1'b1;
      out_frame = mem_q[rd_ptr_q];
    end
`ifdef STIM_IDLE_FILL_EN
    else if (rst_ni) begin
      out_valid = 1'b1;
      out_frame = {7'h01, code_q, data_q};
    end
`else
`endif
  end

  assign bus.stim_valid_o    = out_valid;
  assign bus.sft_irq_o       = out_frame[FW-1];
  assign bus.tmr_irq_o       = out_frame[FW-2];
  assign bus.ext_irq_o       = out_frame[FW-3];
  assign bus.data_addr_ext_o = out_frame[FW-4];
  assign bus.data_ready_o    = out_frame[FW-5];
  assign bus.code_ready_o    = out_frame[FW-6];
  assign bus.stall_o         = out_frame[FW-7];
  assign bus.code_o          = out_frame[2*XLEN-1:XLEN];
  assign bus.data_o          = out_frame[XLEN-1:0];
  assign bus.init_pc_o       = INIT_PC;
  assign bus.frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_fuzz_stim_packer.sv
module tb_fuzz_stim_packer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int NB    = XLEN / 8;
  localparam logic [XLEN-1:0] PC = 32'h8000_0100;

  typedef struct packed {
    logic            hw;
    logic [6:0]      ctrl;
    logic [XLEN-1:0] code;
    logic [XLEN-1:0] data;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fuzz_stim_packer_if #(.XLEN(XLEN)) sif();

  fuzz_stim_packer #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .INIT_PC(PC)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (sif)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: frames accepted by the parser but not yet pushed (pend),
  // frames sitting in the output buffer (fifo_q), and the held words.
  frame_t          pend[$];
  frame_t          fifo_q[$];
  logic [XLEN-1:0] held_code, held_data;
  logic [XLEN-1:0] drv_code, drv_data;
  logic [15:0]     m_cnt;
  logic [6:0]      last_ctrl;
  logic [XLEN-1:0] last_code, last_data;
  int              rdy_mode = 0;
  bit              rnd_gap = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic finish_now();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "bench stopped on timeout");
  endtask

  // Only writer of stim_ready_i.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       sif.stim_ready_i = 1'b0;
      1:       sif.stim_ready_i = 1'b1;
      default: sif.stim_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Checks DUT outputs against the model, then advances the model to what the
  // next rising edge will do.
  always @(negedge clk) begin : mon
    bit         real_f;
    bit         do_pop;
    logic [6:0] got_ctrl;
    frame_t     f;
    if (rst_n) begin
      real_f   = (fifo_q.size() > 0);
      got_ctrl = {sif.sft_irq_o, sif.tmr_irq_o, sif.ext_irq_o, sif.data_addr_ext_o,
                  sif.data_ready_o, sif.code_ready_o, sif.stall_o};
      chk("byte_ready", sif.byte_ready_o, (pend.size() == 0) && (fifo_q.size() < DEPTH));
      chk("frame_cnt", sif.frame_cnt_o, m_cnt);
`ifdef STIM_IDLE_FILL_EN
      chk("stim_valid", sif.stim_valid_o, 1'b1);
      if (!real_f) begin
        chk("idle_ctrl", got_ctrl, 7'h01);
        chk("idle_code", sif.code_o, held_code);
        chk("idle_data", sif.data_o, held_data);
      end
`else
      chk("stim_valid", sif.stim_valid_o, real_f);
`endif
      if (real_f) begin
        chk("frame_ctrl", got_ctrl, fifo_q[0].ctrl);
        chk("frame_code", sif.code_o, fifo_q[0].code);
        chk("frame_data", sif.data_o, fifo_q[0].data);
      end
      do_pop = real_f && (sif.stim_ready_i === 1'b1);
      if (do_pop) begin
        last_ctrl = got_ctrl;
        last_code = sif.code_o;
        last_data = sif.data_o;
        void'(fifo_q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (pend.size() > 0 && fifo_q.size() < DEPTH) begin
        f = pend.pop_front();
        fifo_q.push_back(f);
        if (f.hw) begin
          held_code = f.code;
          held_data = f.data;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sif.byte_valid_i = 1'b0;
    pend.delete();
    fifo_q.delete();
    held_code = '0; held_data = '0;
    drv_code = '0;  drv_data = '0;
    m_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_stim_valid", sif.stim_valid_o, 1'b0);
    chk("rst_byte_ready", sif.byte_ready_o, 1'b0);
    chk("rst_frame_cnt", sif.frame_cnt_o, 16'd0);
    chk("rst_stall", sif.stall_o, 1'b0);
    chk("rst_code", sif.code_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if (rnd_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    sif.byte_i = b;
    sif.byte_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (sif.byte_ready_o === 1'b1) break;
      n++;
      if (n > 300) begin
        chk("byte_timeout", 1'b0, 1'b1);
        finish_now();
      end
    end
    @(posedge clk); #1;
    sif.byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [XLEN-1:0] code,
                            input logic [XLEN-1:0] data);
    frame_t f;
    send_byte(c);
    if (c[7]) begin
      for (int i = 0; i < NB; i++) send_byte(code[i*8 +: 8]);
      for (int i = 0; i < NB; i++) send_byte(data[i*8 +: 8]);
      drv_code = code;
      drv_data = data;
    end
    f.hw   = c[7];
    f.ctrl = c[6:0];
    f.code = drv_code;
    f.data = drv_data;
    pend.push_back(f);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pend.size() != 0 || fifo_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 600) begin
        chk("drain_timeout", 1'b0, 1'b1);
        finish_now();
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    sif.byte_i = '0;
    sif.byte_valid_i = 1'b0;
    sif.stim_ready_i = 1'b0;
    do_reset();
    chk("init_pc", sif.init_pc_o, PC);

    // worded frame
    rdy_mode = 1;
    send_frame(8'h82, 32'h7856_3412, 32'hDEAD_BEEF);
    drain();
    chk("t1_code", last_code, 32'h7856_3412);
    chk("t1_data", last_data, 32'hDEAD_BEEF);
    chk("t1_ctrl", last_ctrl, 7'h02);
    chk("t1_cnt", sif.frame_cnt_o, 16'd1);

    // wordless frame reuses held words
    send_frame(8'h05, '0, '0);
    drain();
    chk("t2_ctrl", last_ctrl, 7'h05);
    chk("t2_code", last_code, 32'h7856_3412);
    chk("t2_data", last_data, 32'hDEAD_BEEF);

    // backpressure: fill buffer with consumer stalled
    do_reset();
    rdy_mode = 0;
    repeat (4) send_frame(8'h02, '0, '0);
    repeat (2) @(negedge clk);
    chk("t3_bp_ready", sif.byte_ready_o, 1'b0);
    chk("t3_bp_valid", sif.stim_valid_o, 1'b1);
    @(posedge clk); #1;
    rdy_mode = 1;
    send_frame(8'h02, '0, '0);
    drain();
    chk("t3_cnt", sif.frame_cnt_o, 16'd5);
    chk("t3_code", last_code, 32'h0);

    // full buffer then streaming with consumer ready: nothing lost, in order
    rdy_mode = 0;
    send_frame(8'h81, 32'hA1A2_A3A4, 32'hB1B2_B3B4);
    send_frame(8'h01, '0, '0);
    send_frame(8'h84, 32'hC1C2_C3C4, 32'hD1D2_D3D4);
    send_frame(8'h08, '0, '0);
    rdy_mode = 1;
    send_frame(8'h10, '0, '0);
    send_frame(8'h20, '0, '0);
    send_frame(8'hC0, 32'h0BAD_F00D, 32'h1234_5678);
    drain();
    chk("t4_cnt", sif.frame_cnt_o, 16'd12);
    chk("t4_ctrl", last_ctrl, 7'h40);
    chk("t4_code", last_code, 32'h0BAD_F00D);

    // reset in the middle of a code word
    send_byte(8'h80);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset();
    rdy_mode = 1;
    send_frame(8'h10, '0, '0);
    drain();
    chk("t5_ctrl", last_ctrl, 7'h10);
    chk("t5_code", last_code, 32'h0);
    chk("t5_data", last_data, 32'h0);
    chk("t5_cnt", sif.frame_cnt_o, 16'd1);

`ifdef STIM_IDLE_FILL_EN
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_valid", sif.stim_valid_o, 1'b1);
      chk("t6_idle_stall", sif.stall_o, 1'b1);
    end
    chk("t6_idle_cnt", sif.frame_cnt_o, 16'd1);
    @(posedge clk); #1;
`endif

    // randomized traffic
    rdy_mode = 2;
    rnd_gap = 1;
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom), XLEN'($urandom), XLEN'($urandom));
    end
    rdy_mode = 1;
    drain();
    chk("rnd_cnt", sif.frame_cnt_o, 16'd41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
